// File: rtl/adiabatic_inv_pipe.sv
// Cycle model of a STAGES-deep, WIDTH-bit adiabatic inverter chain on a 4-phase power clock.
// Optional delivered-word counter is built only when ADIA_WORD_CNT_EN is defined.

module adiabatic_inv_stage #(
  parameter int WIDTH = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       g,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             pwr
);
  typedef enum logic [1:0] {EVAL = 2'd0, HOLD = 2'd1, RECOVER = 2'd2, IDLE = 2'd3} phase_t;

  localparam logic [1:0] OFF = 2'(IDX % 4);

  phase_t ph;
  assign ph  = phase_t'(g - OFF);
  assign pwr = (ph == EVAL) || (ph == HOLD);

  // EVAL captures the inverted upstream word (bubbles load zero); HOLD returns the charge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      case (ph)
        EVAL: begin
          valid <= src_valid;
          data  <= src_valid ? ~src_data : '0;
        end
        HOLD: begin
          valid <= 1'b0;
          data  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

module adiabatic_inv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAGES-1:0] stage_pwr,
  output logic [15:0]       word_cnt
);
  if (STAGES < 1) begin : g_bad_stages
    $error("adiabatic_inv_pipe: STAGES must be >= 1");
  end

  logic [1:0]                    g;
  logic [STAGES:0]               vld_pipe;
  logic [STAGES:0][WIDTH-1:0]    data_pipe;

  always_ff @(posedge clk) begin
    if (rst)     g <= 2'd0;
    else if (en) g <= g + 2'd1;
  end

  // Stage 0 only evaluates when g==0, so the source valid needs no extra gating.
  assign in_ready     = en && (g == 2'd0);
  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = in_data;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    adiabatic_inv_stage #(.WIDTH(WIDTH), .IDX(s)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .g         (g),
      .src_valid (vld_pipe[s]),
      .src_data  (data_pipe[s]),
      .valid     (vld_pipe[s+1]),
      .data      (data_pipe[s+1]),
      .pwr       (stage_pwr[s])
    );
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = data_pipe[STAGES];

`ifdef ADIA_WORD_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                    word_cnt <= 16'h0000;
    else if (out_valid && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
  end
`else
  assign word_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_adiabatic_inv_pipe.sv
// Scoreboard bench for adiabatic_inv_pipe: predictor queues expected deliveries, monitor checks each cycle.
// Honours ADIA_WORD_CNT_EN the same way as the design.

module tb_adiabatic_inv_pipe;
  localparam int WIDTH  = 8;
  localparam int STAGES = 4;

  logic              clk = 1'b0;
  logic              rst, en, in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic [STAGES-1:0] stage_pwr;
  logic [15:0]       word_cnt;

  adiabatic_inv_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .stage_pwr (stage_pwr),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;   // enabled-cycle count at which the word first appears
  } exp_t;

  exp_t q[$];
  int   ecnt     = 0;   // enabled cycles since reset (phase = ecnt mod 4)
  int   checks   = 0;
  int   failures = 0;
  int   wcnt     = 0;
  int   delivered = 0;
  bit   armed    = 0;
  bit   last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // Predictor: acceptance happens on an enabled phase-0 cycle outside reset.
  initial begin
    forever begin
      @(posedge clk);
      last_acc = 0;
      if (rst) ecnt = 0;
      else if (en) begin
        if (in_valid && (ecnt % 4 == 0)) begin
          exp_t e;
          e.data = (STAGES % 2 == 1) ? ~in_data : in_data;
          e.due  = ecnt + STAGES;
          q.push_back(e);
          last_acc = 1;
        end
        ecnt++;
      end
    end
  end

  // Monitor: compare every output against the predicted state, pop on delivery.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        bit               ev;
        logic [WIDTH-1:0] ed;
        logic [STAGES-1:0] ep;
        ev = (q.size() > 0) && (q[0].due == ecnt);
        ed = ev ? q[0].data : '0;
        for (int s = 0; s < STAGES; s++) ep[s] = (((ecnt - s) % 4 + 4) % 4) < 2;
        check("out_valid", 32'(out_valid), 32'(ev));
        check("out_data",  32'(out_data),  32'(ed));
        check("in_ready",  32'(in_ready),  32'(en && (ecnt % 4 == 0)));
        check("stage_pwr", 32'(stage_pwr), 32'(ep));
`ifdef ADIA_WORD_CNT_EN
        check("word_cnt",  32'(word_cnt),  32'(wcnt));
`else
        check("word_cnt",  32'(word_cnt),  32'd0);
`endif
        if (rst) begin
          q.delete();
          wcnt = 0;
        end else begin
          if (ev && wcnt < 65535) wcnt++;
          if (ev && en) begin
            void'(q.pop_front());
            delivered++;
          end
        end
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] words[4];
    int wi;
    words[0] = 8'hA5; words[1] = 8'h01; words[2] = 8'h02; words[3] = 8'h03;
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #1;
    armed = 1;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b1;

    // Directed: A5 then 01,02,03 with in_valid held, each advanced on acceptance.
    wi = 0;
    in_valid = 1'b1; in_data = words[0];
    for (int c = 0; c < 40 && wi < 4; c++) begin
      @(posedge clk); #1;
      if (last_acc) begin
        wi++;
        if (wi < 4) in_data = words[wi];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("directed_delivered", 32'(delivered), 32'd4);

    // Directed stall mid-flight: two en=0 cycles after acceptance.
    in_valid = 1'b1; in_data = 8'h3C;
    for (int c = 0; c < 8 && !last_acc; c++) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; en = 1'b1;
    repeat (8) begin @(posedge clk); #1; end

    // Directed reset two cycles after acceptance: that word must vanish.
    in_valid = 1'b1; in_data = 8'hC3;
    for (int c = 0; c < 8 && !last_acc; c++) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    // Random traffic with stalls and occasional resets; data held until accepted.
    in_data = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (last_acc || !in_valid) in_data = 8'($urandom);
      en       = ($urandom % 6) != 0;
      rst      = ($urandom % 200) == 0;
      if (!in_valid || last_acc) in_valid = ($urandom % 4) != 0;
    end

    // Drain: everything issued must come out.
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    repeat (STAGES + 8) begin @(posedge clk); #1; end
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
